// File: rtl/cache_mem_ctrl_if.sv
// Cache-side request/acknowledge bus of cache_mem_ctrl.
// Signal names match the controller's documented port list.
interface cache_mem_ctrl_if;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_rd;
  logic        i_wr;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic        o_err;

  modport master (output i_addr, i_wdata, i_rd, i_wr,
                  input  o_ack, o_rdata, o_busy, o_err);
  modport slave  (input  i_addr, i_wdata, i_rd, i_wr,
                  output o_ack, o_rdata, o_busy, o_err);
endinterface

// File: rtl/cache_mem_ctrl.sv
// Memory-side controller: single-cycle cache requests -> SRAM strobe + wait states -> one-cycle ack.
// Optional MEM_CTRL_RANGE_CHECK_EN flags word indices >= DEPTH and suppresses their SRAM strobe.
module cache_mem_ctrl #(
  parameter int AW          = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cache_mem_ctrl_if.slave   bus,
  output logic              o_sram_ce,
  output logic              o_sram_we,
  output logic [AW-1:0]     o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  input  logic [31:0]       i_sram_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          wr_q, err_q;
  logic [3:0]    cnt_q;
  logic          accept, range_err;

  assign accept = ((state_q == S_IDLE) || (state_q == S_ACK)) && (bus.i_rd || bus.i_wr);

`ifdef MEM_CTRL_RANGE_CHECK_EN
  assign range_err = ({2'b00, bus.i_addr[31:2]} >= 32'(DEPTH));
`else
  assign range_err = 1'b0;
`endif

  // Address bits outside the word index are intentionally dropped in the default build.
  logic unused_addr;
  assign unused_addr = ^{bus.i_addr, 32'(DEPTH)};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_sram_ce    = 1'b0;
    o_sram_we    = 1'b0;
    bus.o_ack    = 1'b0;
    bus.o_busy   = 1'b0;
    bus.o_err    = 1'b0;
    bus.o_rdata  = 32'h0;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_STROBE;
      S_STROBE: begin
        state_d    = S_WAIT;
        bus.o_busy = 1'b1;
        o_sram_ce  = !err_q;
        o_sram_we  = !err_q && wr_q;
      end
      S_WAIT: begin
        bus.o_busy = 1'b1;
        if (cnt_q == 4'd0) state_d = S_ACK;
      end
      S_ACK: begin
        state_d   = accept ? S_STROBE : S_IDLE;
        bus.o_ack = 1'b1;
        bus.o_err = err_q;
        if (!wr_q) bus.o_rdata = err_q ? 32'hDEAD_BEEF : rdata_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latches stay put between requests so the SRAM address/data lines hold steady.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.i_addr[AW+1:2];
        wdata_q <= bus.i_wdata;
        wr_q    <= bus.i_wr;
        err_q   <= range_err;
      end
      if (state_q == S_STROBE) cnt_q <= 4'(WAIT_CYCLES);
      if (state_q == S_WAIT) begin
        if (cnt_q == 4'd0) rdata_q <= i_sram_rdata;
        else               cnt_q   <= cnt_q - 4'd1;
      end
    end
  end

  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a latency-accurate SRAM model (WAIT_CYCLES=1, DEPTH=512).
module tb_cache_mem_ctrl;
  localparam int AW = 10;
  localparam int DEPTH = 512;
  localparam int W = 1;
`ifdef MEM_CTRL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  int            total = 0, bad = 0;
  int            ce_cnt = 0, ack_cnt = 0;

  cache_mem_ctrl_if bus();

  cache_mem_ctrl #(.AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus),
    .o_sram_ce(sram_ce), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata));

  always #5 i_clk = ~i_clk;

  // SRAM model: unwritten word a reads 0x1000_0000+a; data valid only W+1 cycles after the strobe.
  logic [31:0] wmem [0:1023];
  bit          written [0:1023];
  logic [31:0] pd [0:W];
  bit          pv [0:W];

  always @(posedge i_clk) begin
    pv[0] <= sram_ce && !sram_we;
    pd[0] <= written[sram_addr] ? wmem[sram_addr] : 32'h1000_0000 + 32'(sram_addr);
    for (int k = 1; k <= W; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    if (sram_ce && sram_we) begin
      wmem[sram_addr]    <= sram_wdata;
      written[sram_addr] <= 1'b1;
    end
    if (sram_ce)   ce_cnt  <= ce_cnt + 1;
    if (bus.o_ack) ack_cnt <= ack_cnt + 1;
  end

  assign sram_rdata = pv[W] ? pd[W] : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ack"},   32'(bus.o_ack),   0);
    chk({tag, ".busy"},  32'(bus.o_busy),  0);
    chk({tag, ".err"},   32'(bus.o_err),   0);
    chk({tag, ".rdata"}, bus.o_rdata,      0);
    chk({tag, ".ce"},    32'(sram_ce),     0);
    chk({tag, ".we"},    32'(sram_we),     0);
    chk({tag, ".addr"},  32'(sram_addr),   0);
    chk({tag, ".wdata"}, sram_wdata,       0);
  endtask

  // Issue a request at the current negedge; ends at the negedge of the ack cycle.
  task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int saddr, input logic exp_ce, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    bus.i_rd = rd; bus.i_wr = wr; bus.i_addr = addr; bus.i_wdata = wdata;
    @(negedge i_clk);
    bus.i_rd = 1'b0; bus.i_wr = 1'b0;
    chk({tag, ".c1.ce"},    32'(sram_ce),   32'(exp_ce));
    chk({tag, ".c1.we"},    32'(sram_we),   32'(exp_ce & wr));
    chk({tag, ".c1.addr"},  32'(sram_addr), 32'(saddr));
    chk({tag, ".c1.wdata"}, sram_wdata,     wdata);
    chk({tag, ".c1.busy"},  32'(bus.o_busy), 1);
    @(negedge i_clk);
    chk({tag, ".c2.busy"},  32'(bus.o_busy), 1);
    chk({tag, ".c2.ce"},    32'(sram_ce),    0);
    repeat (W) @(negedge i_clk);
    chk({tag, ".c3.ack"},   32'(bus.o_ack),  0);
    @(negedge i_clk);
    chk({tag, ".ack"},      32'(bus.o_ack),  1);
    chk({tag, ".rdata"},    bus.o_rdata,     exp_rdata);
    chk({tag, ".err"},      32'(bus.o_err),  32'(exp_err));
    chk({tag, ".busy"},     32'(bus.o_busy), 0);
  endtask

  initial begin
    int c0, a0;
    bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;

    // Reset held: request toggling must not move any output.
    repeat (2) @(negedge i_clk);
    bus.i_rd = 1'b1; bus.i_addr = 32'h0000_0010;
    @(negedge i_clk);
    chk_all_zero("rst_a");
    bus.i_wr = 1'b1; bus.i_addr = 32'hFFFF_FFFC; bus.i_wdata = 32'h1234_5678;
    @(negedge i_clk);
    chk_all_zero("rst_b");
    bus.i_rd = 1'b0; bus.i_wr = 1'b0;
    @(negedge i_clk);
    chk_all_zero("rst_c");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4, 1'b1, 32'h1000_0004, 1'b0, "rd10");
    @(negedge i_clk);
    chk("rd10.idle_ack", 32'(bus.o_ack), 0);

    run(1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1023, !RC, 32'h0, RC, "wrFFC");
    @(negedge i_clk);
    run(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1023, !RC,
        RC ? 32'hDEAD_BEEF : 32'hCAFE_F00D, RC, "rdFFC");
    @(negedge i_clk);

    // Chained: second request presented in the first ack cycle.
    run(1'b0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 8, 1'b1, 32'h0, 1'b0, "wr20");
    run(1'b1, 1'b0, 32'h0000_0040, 32'h0, 16, 1'b1, 32'h1000_0010, 1'b0, "rd40");
    @(negedge i_clk);
    chk("rd40.idle_ack", 32'(bus.o_ack), 0);
    run(1'b1, 1'b0, 32'h0000_0020, 32'h0, 8, 1'b1, 32'h5555_AAAA, 1'b0, "rd20");
    @(negedge i_clk);

    // rd and wr together is a write.
    run(1'b1, 1'b1, 32'h0000_0070, 32'hA5A5_0F0F, 28, 1'b1, 32'h0, 1'b0, "rdwr70");
    @(negedge i_clk);
    run(1'b1, 1'b0, 32'h0000_0070, 32'h0, 28, 1'b1, 32'hA5A5_0F0F, 1'b0, "rd70");
    @(negedge i_clk);

    // Busy collision: a pulse during WAIT is dropped.
    c0 = ce_cnt; a0 = ack_cnt;
    bus.i_rd = 1'b1; bus.i_addr = 32'h0000_0050;
    @(negedge i_clk); bus.i_rd = 1'b0;
    @(negedge i_clk); bus.i_rd = 1'b1; bus.i_addr = 32'h0000_0060;
    @(negedge i_clk); bus.i_rd = 1'b0;
    @(negedge i_clk);
    chk("coll.ack", 32'(bus.o_ack), 1);
    chk("coll.rdata", bus.o_rdata, 32'h1000_0014);
    repeat (6) @(negedge i_clk);
    chk("coll.ce_count", 32'(ce_cnt - c0), 1);
    chk("coll.ack_count", 32'(ack_cnt - a0), 1);

    // Reset asserted during the write strobe aborts it.
    bus.i_wr = 1'b1; bus.i_addr = 32'h0000_0030; bus.i_wdata = 32'h1234_5678;
    @(negedge i_clk); bus.i_wr = 1'b0;
    chk("rmid.strobe", 32'(sram_ce), 1);
    a0 = ack_cnt;
    i_rst_n = 1'b0;
    #1;
    chk("rmid.ce_off", 32'(sram_ce), 0);
    chk("rmid.busy_off", 32'(bus.o_busy), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rmid.no_ack", 32'(ack_cnt - a0), 0);
    chk("rmid.busy", 32'(bus.o_busy), 0);
    chk("rmid.addr", 32'(sram_addr), 0);
    run(1'b1, 1'b0, 32'h0000_0030, 32'h0, 12, 1'b1, 32'h1000_000C, 1'b0, "rd30");
    @(negedge i_clk);

    // Word 512 is beyond DEPTH=512.
    run(1'b1, 1'b0, 32'h0000_0800, 32'h0, 512, !RC,
        RC ? 32'hDEAD_BEEF : 32'h1000_0200, RC, "rd800");
    @(negedge i_clk);
    chk("end.ack", 32'(bus.o_ack), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Memory-side controller sitting directly downstream of the 2-way data cache. It accepts the cache's single-cycle read/write request pulses (write-back of a dirty line, line fill), drives a synchronous single-port SRAM with a configurable number of wait states, and returns a one-cycle acknowledge with read data. It accepts a new request in the same cycle it acknowledges, so the cache can issue a write-back followed immediately by a fill.

## Interface
- AW, 10: SRAM word-address width.
- DEPTH, 1024: number of implemented words, at most 2**AW; used only by the range check.
- WAIT_CYCLES, 1: extra SRAM read-latency cycles, 0..15.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_addr  in  32  byte address from cache; bits [1:0] ignored.
- i_wdata  in  32  write data, valid with i_wr.
- i_rd  in  1  read request pulse.
- i_wr  in  1  write request pulse.
- o_ack  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data, valid only while o_ack=1 for a read.
- o_busy  out  1  high in every non-IDLE state except ACK.
- o_err  out  1  range error, valid with o_ack.
- o_sram_ce  out  1  SRAM chip enable, one-cycle strobe.
- o_sram_we  out  1  SRAM write enable, qualified by o_sram_ce.
- o_sram_addr  out  AW  SRAM word address, i_addr[AW+1:2].
- o_sram_wdata  out  32  SRAM write data.
- i_sram_rdata  in  32  SRAM read data, valid WAIT_CYCLES+1 cycles after the strobe cycle.

## Operation
- States: IDLE, STROBE, WAIT, ACK.
- A request is accepted when the state is IDLE or ACK and i_rd|i_wr=1. On acceptance, the address, write data and op are latched, and the next state is STROBE.
- If i_rd and i_wr are both high, the request is a write.
- Requests arriving in STROBE or WAIT are ignored. No queueing is performed.
- STROBE: o_sram_ce=1, o_sram_we=op_is_write, and the address and wdata are driven from the latches. The wait counter loads WAIT_CYCLES. Next state is WAIT.
- WAIT: lasts WAIT_CYCLES+1 cycles. The counter decrements each cycle. In the cycle the counter reaches 0, i_sram_rdata is captured into the read-data register, and next state is ACK.
- ACK: o_ack=1 for exactly one cycle. For reads, o_rdata equals the captured word; for writes, o_rdata=0.
- From ACK, the next state is STROBE if a new request is present that cycle, otherwise IDLE.
- Writes use the same latency as reads, so the cache sees uniform timing.
- Reset values: all outputs are 0; the state is IDLE; all latches, the counter and the read-data register are 0.
- Reset asserted mid-operation aborts the access immediately, with no ack and no further strobe. After reset release the block is in IDLE and the aborted request is lost.
- o_sram_ce is 0 in every state except STROBE.
- o_sram_addr and o_sram_wdata hold the latched values between requests.

## Timing
- Request sampled in cycle 0 → STROBE in cycle 1 → WAIT in cycles 2..2+WAIT_CYCLES → o_ack in cycle 3+WAIT_CYCLES.
- Latency is WAIT_CYCLES+3 cycles. With the default WAIT_CYCLES=1, a cycle-0 request is acknowledged in cycle 4.
- Back-to-back requests: a request presented in the ACK cycle gets its own o_ack WAIT_CYCLES+3 cycles later. Minimum request spacing is WAIT_CYCLES+3.
- o_ack, o_busy and o_err are registered state decodes with no combinational path from i_rd or i_wr.

## Configuration
- Macro: MEM_CTRL_RANGE_CHECK_EN.
- Defined: an accepted request whose word index i_addr[31:2] ≥ DEPTH proceeds as follows:
  - no SRAM strobe is issued (ce stays 0);
  - latency is unchanged;
  - in the ACK cycle, o_err=1 and o_rdata=32'hDEAD_BEEF for reads, 0 for writes;
  - the SRAM contents are unchanged.
- Not defined: o_err is tied to 0, upper address bits are discarded, and the access wraps modulo 2**AW.

## Test plan
- Reset check: hold i_rst_n=0, toggle i_rd and i_wr → all outputs stay 0. Release, then read 0x0000_0010 → o_sram_addr=4 with ce=1, we=0 in cycle 1; o_ack in cycle 4 with o_rdata equal to the SRAM model word 4.
- Write then read-back: write 0xCAFE_F00D to 0x0000_0FFC → strobe we=1 at addr 1023. Read the same address → o_rdata=0xCAFE_F00D, latency 4 for both.
- Chained access: write 0x0000_0020; in the ACK cycle assert a read of 0x0000_0040 → second strobe at addr 16 in the cycle after the first ack; second ack 4 cycles after the first.
- Busy collision: pulse i_rd in cycle 2 while in WAIT → no extra strobe, exactly one o_ack.
- Reset mid-op: assert i_rst_n=0 in the STROBE cycle of a write, release 2 cycles later → no o_ack, state IDLE, next read completes normally.
- Range check, with MEM_CTRL_RANGE_CHECK_EN and DEPTH=512: read 0x0000_0800 → no ce, o_ack in cycle 4 with o_err=1 and o_rdata=0xDEAD_BEEF. Without the macro: access goes to addr 512, o_err=0.
